es8psk_ber_ctrl: RTL and testbench
==================================

// Module: es8psk_ber_ctrl
// PURPOSE
//  Sequencer for one 8-PSK link BER measurement run. Sits beside es8psk_trans / es8psk_rec / tester_channel on clk_dec.
//  Clears the tester counters, gates the transmitter for exactly n_frames frames, and drains the receive pipeline.
//  Accumulates per-frame bit errors, then reports done/pass/timeout to the bench or host.
// PARAMETERS
//  TIMEOUT   4096  clk cycles allowed with no ena_data_rx, in RUN or DRAIN, before the run is aborted as timed out
//  FW        16    width of the frame counters and of n_frames
//  EW        32    width of err_limit and err_total
//  PW        8     width of frame_err
// PORTS
//  clk           in   1   symbol-rate clock (clk_dec domain); all logic on rising edge
//  reset_b       in   1   asynchronous, active-high reset (1 = in reset)
//  start         in   1   1-cycle pulse: begin a run; honoured only in IDLE or DONE
//  abort         in   1   level/pulse: return to IDLE immediately; has priority over start
//  n_frames      in   FW  frames to transmit; sampled in the cycle start is accepted
//  err_limit     in   EW  max total bit errors for pass; sampled with n_frames
//  ena_data_tx   in   1   transmitter frame strobe: 1 cycle per frame taken by es8psk_trans
//  ena_data_rx   in   1   receiver frame strobe: 1 cycle per decoded frame
//  frame_err     in   PW  bit errors in the current rx frame; valid only while ena_data_rx=1
//  tx_enable     out  1   gates data source into es8psk_trans; 1 only in RUN
//  clr_cnt       out  1   1-cycle pulse clearing tester_channel err/bits counters
//  busy          out  1   1 in CLEAR, RUN, DRAIN
//  done          out  1   1 in DONE; held until next accepted start or abort
//  pass          out  1   valid when done=1: (!timeout_flag && err_total <= err_limit)
//  timeout_flag  out  1   set on timeout; cleared in CLEAR
//  frames_tx     out  FW  ena_data_tx strobes counted in RUN
//  frames_rx     out  FW  ena_data_rx strobes counted in RUN/DRAIN; saturates at all-ones
//  err_total     out  EW  sum of frame_err over counted rx frames; saturates at all-ones
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including the counters.
//  Registered outputs: every output changes on the clk edge after the causing event.
//  FSM: IDLE -> CLEAR -> RUN -> DRAIN -> DONE, plus DONE -> CLEAR on start, and any -> IDLE on abort.
//  IDLE:  start=1 -> CLEAR; latch n_frames and err_limit.
//  CLEAR: exactly 1 cycle.
//   - clr_cnt=1; zero frames_tx, frames_rx, err_total, timeout_flag and the idle timer.
//   - Next state: latched n_frames==0 -> DONE (pass=1); otherwise -> RUN.
//  RUN:   tx_enable=1.
//   - Each ena_data_tx increments frames_tx.
//   - When the increment makes frames_tx==n_frames: -> DRAIN. tx_enable=0 from the next cycle.
//   - ena_data_tx outside RUN is not counted.
//  DRAIN: tx_enable=0.
//   - Exit to DONE when frames_rx >= frames_tx, evaluated after this cycle's update.
//  Rx accounting in RUN/DRAIN:
//   - ena_data_rx=1 -> frames_rx+1 and err_total += zero-extended frame_err, both saturating.
//   - Rx strobes in IDLE/CLEAR/DONE are ignored.
//  Timeout timer (counts to TIMEOUT):
//   - Zeroed on entry to RUN and on every ena_data_rx; otherwise increments in RUN/DRAIN.
//   - On reaching TIMEOUT-1 with no strobe: timeout_flag=1, -> DONE.
//  DONE:  done=1; pass computed combinationally from the latched err_limit and registered as above.
//   - Counters frozen.
//   - start -> CLEAR with new n_frames/err_limit.
//  Simultaneous events:
//   - abort wins over everything.
//   - ena_data_rx and the timeout in the same cycle: the strobe wins and the timer restarts.
//   - ena_data_tx that completes the frame count and ena_data_rx in the same cycle: both are counted.
//  start while busy is ignored; n_frames/err_limit changes mid-run have no effect.
//  abort or reset mid-run: tx_enable drops next edge (async on reset); done=0.
//   - Counters keep their values on abort; they are cleared on reset.
// TESTING
//  1 n_frames=4, err_limit=0, tx strobes every 16 clk, rx echoes each 8 clk later with frame_err=0
//    -> clr_cnt 1 pulse; tx_enable high for 4 strobes; done=1, pass=1, frames_rx=4, err_total=0.
//  2 As 1 with frame_err=3 on every frame, err_limit=11 -> err_total=12, pass=0; rerun with err_limit=12 -> pass=1.
//  3 n_frames=2, TIMEOUT=64, no ena_data_rx -> timeout_flag=1, done=1, pass=0 at 64 clk after RUN entry.
//  4 n_frames=0 -> CLEAR then DONE on the next cycle; pass=1; tx_enable never asserted.
//  5 abort during DRAIN, then start -> done stays 0 until the new run completes; clr_cnt pulses again;
//    start pulsed during RUN is ignored.
//  6 frame_err=8'hFF, err_total preloaded near max (EW=8 build) -> err_total saturates at 8'hFF with no wrap.

Source files
------------

// File: rtl/es8psk_ber_ctrl.sv
// es8psk_ber_ctrl
//   Sequencer for one 8-PSK link BER measurement run, on the decoder clock.
//   It clears the tester counters and gates the transmitter for exactly
//   n_frames frames. It then waits for the receive pipeline to drain, sums the
//   per-frame bit errors, and reports done / pass / timeout.
//
// Ports
//   clk           symbol-rate clock, rising edge
//   reset_b       asynchronous reset, active HIGH despite the suffix
//   start         1-cycle pulse, accepted only in IDLE or DONE
//   abort         returns to IDLE at once, priority over everything
//   n_frames      frames to transmit, latched when start is accepted
//   err_limit     max total bit errors for pass, latched with n_frames
//   ena_data_tx   transmitter frame strobe
//   ena_data_rx   receiver frame strobe
//   frame_err     bit errors of the current rx frame (valid with ena_data_rx)
//   tx_enable     data-source gate, high only in RUN
//   clr_cnt       one-cycle clear pulse for the tester counters (CLEAR)
//   busy          high in CLEAR, RUN, DRAIN
//   done          high in DONE
//   pass          valid with done: no timeout and err_total <= err_limit
//   timeout_flag  set when the rx idle timer expires
//   frames_tx     tx strobes counted in RUN
//   frames_rx     rx strobes counted in RUN/DRAIN (saturating)
//   err_total     summed frame_err over counted rx frames (saturating)
//
// All outputs are registered; each one is decoded from the next-state values.

module es8psk_ber_ctrl #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned FW      = 16,
  parameter int unsigned EW      = 32,
  parameter int unsigned PW      = 8
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] n_frames,
  input  logic [EW-1:0] err_limit,
  input  logic          ena_data_tx,
  input  logic          ena_data_rx,
  input  logic [PW-1:0] frame_err,
  output logic          tx_enable,
  output logic          clr_cnt,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout_flag,
  output logic [FW-1:0] frames_tx,
  output logic [FW-1:0] frames_rx,
  output logic [EW-1:0] err_total
);

  localparam int unsigned   TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] n_frames_q, n_frames_d;
  logic [EW-1:0] err_limit_q, err_limit_d;
  logic [FW-1:0] frames_tx_q, frames_tx_d;
  logic [FW-1:0] frames_rx_q, frames_rx_d;
  logic [EW-1:0] err_total_q, err_total_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
  logic          pass_d;
  logic [EW:0]   err_sum;

  // One extra bit catches the carry out so the total can saturate.
  assign err_sum = {1'b0, err_total_q} + (EW+1)'(frame_err);

  always_comb begin
    state_d     = state_q;
    n_frames_d  = n_frames_q;
    err_limit_d = err_limit_q;
    frames_tx_d = frames_tx_q;
    frames_rx_d = frames_rx_q;
    err_total_d = err_total_q;
    timer_d     = timer_q;
    timeout_d   = timeout_q;

    if (abort) begin
      // Counters and flags keep their values so the host can inspect them.
      state_d = S_IDLE;
    end else begin
      if ((state_q == S_RUN || state_q == S_DRAIN) && ena_data_rx) begin
        frames_rx_d = (frames_rx_q == '1) ? frames_rx_q : frames_rx_q + FW'(1);
        err_total_d = err_sum[EW] ? '1 : err_sum[EW-1:0];
      end

      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d     = S_CLEAR;
            n_frames_d  = n_frames;
            err_limit_d = err_limit;
            frames_tx_d = '0;
            frames_rx_d = '0;
            err_total_d = '0;
            timer_d     = '0;
            timeout_d   = 1'b0;
          end
        end
        S_CLEAR: begin
          timer_d = '0;
          state_d = (n_frames_q == '0) ? S_DONE : S_RUN;
        end
        S_RUN, S_DRAIN: begin
          if (state_q == S_RUN) begin
            if (ena_data_tx) begin
              frames_tx_d = frames_tx_q + FW'(1);
              if (frames_tx_d == n_frames_q) state_d = S_DRAIN;
            end
          end else if (frames_rx_d >= frames_tx_q) begin
            state_d = S_DONE;
          end
          // A strobe arriving in the expiry cycle still restarts the timer.
          if (ena_data_rx) begin
            timer_d = '0;
          end else if (timer_q == TMAX) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    pass_d = (state_d == S_DONE) && !timeout_d && (err_total_d <= err_limit_d);
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state_q      <= S_IDLE;
      n_frames_q   <= '0;
      err_limit_q  <= '0;
      frames_tx_q  <= '0;
      frames_rx_q  <= '0;
      err_total_q  <= '0;
      timer_q      <= '0;
      timeout_q    <= 1'b0;
      tx_enable    <= 1'b0;
      clr_cnt      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_frames_q   <= n_frames_d;
      err_limit_q  <= err_limit_d;
      frames_tx_q  <= frames_tx_d;
      frames_rx_q  <= frames_rx_d;
      err_total_q  <= err_total_d;
      timer_q      <= timer_d;
      timeout_q    <= timeout_d;
      tx_enable    <= (state_d == S_RUN);
      clr_cnt      <= (state_d == S_CLEAR);
      busy         <= (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_DRAIN);
      done         <= (state_d == S_DONE);
      pass         <= pass_d;
    end
  end

  assign timeout_flag = timeout_q;
  assign frames_tx    = frames_tx_q;
  assign frames_rx    = frames_rx_q;
  assign err_total    = err_total_q;

endmodule

// File: tb/tb_es8psk_ber_ctrl.sv
module tb_es8psk_ber_ctrl;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        start, abort;
  logic [15:0] n_frames;
  logic [31:0] err_limit;
  logic        ena_data_tx, ena_data_rx;
  logic [7:0]  frame_err;

  logic        tx_enable, clr_cnt, busy, done, pass, timeout_flag;
  logic [15:0] frames_tx, frames_rx;
  logic [31:0] err_total;

  logic        tx_enable8, clr_cnt8, busy8, done8, pass8, timeout_flag8;
  logic [15:0] frames_tx8, frames_rx8;
  logic [7:0]  err_total8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  es8psk_ber_ctrl #(.TIMEOUT(64), .FW(16), .EW(32), .PW(8)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .abort(abort),
    .n_frames(n_frames), .err_limit(err_limit),
    .ena_data_tx(ena_data_tx), .ena_data_rx(ena_data_rx), .frame_err(frame_err),
    .tx_enable(tx_enable), .clr_cnt(clr_cnt), .busy(busy), .done(done), .pass(pass),
    .timeout_flag(timeout_flag), .frames_tx(frames_tx), .frames_rx(frames_rx),
    .err_total(err_total)
  );

  es8psk_ber_ctrl #(.TIMEOUT(64), .FW(16), .EW(8), .PW(8)) dut8 (
    .clk(clk), .reset_b(reset_b), .start(start), .abort(abort),
    .n_frames(n_frames), .err_limit(err_limit[7:0]),
    .ena_data_tx(ena_data_tx), .ena_data_rx(ena_data_rx), .frame_err(frame_err),
    .tx_enable(tx_enable8), .clr_cnt(clr_cnt8), .busy(busy8), .done(done8), .pass(pass8),
    .timeout_flag(timeout_flag8), .frames_tx(frames_tx8), .frames_rx(frames_rx8),
    .err_total(err_total8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run and plays a transmitter (strobe at t%16==8 while enabled)
  // and a receiver echo 8 cycles later, until done or the budget runs out.
  task automatic run_link(input int nf, input int lim, input logic [7:0] fe,
                          input bit rx_on, input int budget,
                          output int clr_seen, output int txen_cyc,
                          output int t_done, output bit done_at_start);
    int t, tx_sent, rx_sent;
    n_frames  = 16'(nf);
    err_limit = 32'(lim);
    frame_err = fe;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0; tx_sent = 0; rx_sent = 0; txen_cyc = 0; t_done = -1;
    clr_seen = int'(clr_cnt);
    done_at_start = done;
    while (t < budget && t_done < 0) begin
      ena_data_tx = (t % 16 == 8) && tx_enable && (tx_sent < nf);
      ena_data_rx = rx_on && (t % 16 == 0) && (rx_sent < tx_sent);
      if (ena_data_tx) tx_sent++;
      if (ena_data_rx) rx_sent++;
      tick();
      t++;
      ena_data_tx = 1'b0;
      ena_data_rx = 1'b0;
      clr_seen += int'(clr_cnt);
      txen_cyc += int'(tx_enable);
      if (done) t_done = t;
    end
  endtask

  task automatic test_reset();
    reset_b = 1'b1;
    start = 0; abort = 0; n_frames = 0; err_limit = 0;
    ena_data_tx = 0; ena_data_rx = 0; frame_err = 0;
    tick(); tick();
    checks++;
    if ({tx_enable, clr_cnt, busy, done, pass, timeout_flag} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000",
                         {tx_enable, clr_cnt, busy, done, pass, timeout_flag});
    end
    checks++;
    if (frames_tx !== 16'd0 || frames_rx !== 16'd0 || err_total !== 32'd0) begin
      errors++; $display("FAIL reset_counters: got tx=%0d rx=%0d err=%0d expected 0 0 0",
                         frames_tx, frames_rx, err_total);
    end
    reset_b = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_nominal();
    int clr_seen, txen_cyc, t_done;
    bit d0;
    run_link(4, 0, 8'd0, 1'b1, 200, clr_seen, txen_cyc, t_done, d0);
    checks++;
    if (clr_seen !== 1) begin
      errors++; $display("FAIL nom_clr_pulses: got %0d expected 1", clr_seen);
    end
    checks++;
    if (txen_cyc !== 56) begin
      errors++; $display("FAIL nom_txen_cycles: got %0d expected 56", txen_cyc);
    end
    checks++;
    if (t_done !== 65) begin
      errors++; $display("FAIL nom_done_time: got %0d expected 65", t_done);
    end
    checks++;
    if (pass !== 1'b1 || frames_tx !== 16'd4 || frames_rx !== 16'd4 || err_total !== 32'd0) begin
      errors++; $display("FAIL nom_result: got pass=%b tx=%0d rx=%0d err=%0d expected 1 4 4 0",
                         pass, frames_tx, frames_rx, err_total);
    end
    // Rx strobes in DONE must not be counted.
    frame_err = 8'd5; ena_data_rx = 1'b1;
    tick();
    ena_data_rx = 1'b0;
    tick();
    checks++;
    if (frames_rx !== 16'd4 || err_total !== 32'd0 || done !== 1'b1) begin
      errors++; $display("FAIL nom_rx_in_done: got rx=%0d err=%0d done=%b expected 4 0 1",
                         frames_rx, err_total, done);
    end
  endtask

  task automatic test_err_limit();
    int clr_seen, txen_cyc, t_done;
    bit d0;
    run_link(4, 11, 8'd3, 1'b1, 200, clr_seen, txen_cyc, t_done, d0);
    checks++;
    if (d0 !== 1'b0) begin
      errors++; $display("FAIL lim_done_drops: got done=%b expected 0 in CLEAR", d0);
    end
    checks++;
    if (t_done !== 65 || err_total !== 32'd12 || pass !== 1'b0) begin
      errors++; $display("FAIL lim_over: got t=%0d err=%0d pass=%b expected 65 12 0",
                         t_done, err_total, pass);
    end
    run_link(4, 12, 8'd3, 1'b1, 200, clr_seen, txen_cyc, t_done, d0);
    checks++;
    if (t_done !== 65 || err_total !== 32'd12 || pass !== 1'b1) begin
      errors++; $display("FAIL lim_equal: got t=%0d err=%0d pass=%b expected 65 12 1",
                         t_done, err_total, pass);
    end
  endtask

  task automatic test_timeout();
    int clr_seen, txen_cyc, t_done;
    bit d0;
    run_link(2, 100, 8'd0, 1'b0, 200, clr_seen, txen_cyc, t_done, d0);
    checks++;
    if (t_done !== 65) begin
      errors++; $display("FAIL to_time: got %0d expected 65", t_done);
    end
    checks++;
    if (timeout_flag !== 1'b1 || pass !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL to_flags: got to=%b pass=%b done=%b expected 1 0 1",
                         timeout_flag, pass, done);
    end
    checks++;
    if (txen_cyc !== 24 || frames_tx !== 16'd2 || frames_rx !== 16'd0) begin
      errors++; $display("FAIL to_counts: got txen=%0d tx=%0d rx=%0d expected 24 2 0",
                         txen_cyc, frames_tx, frames_rx);
    end
  endtask

  task automatic test_zero_frames();
    int clr_seen, txen_cyc, t_done;
    bit d0;
    run_link(0, 0, 8'd0, 1'b1, 50, clr_seen, txen_cyc, t_done, d0);
    checks++;
    if (clr_seen !== 1 || t_done !== 1 || txen_cyc !== 0) begin
      errors++; $display("FAIL zero_seq: got clr=%0d t=%0d txen=%0d expected 1 1 0",
                         clr_seen, t_done, txen_cyc);
    end
    checks++;
    if (pass !== 1'b1 || timeout_flag !== 1'b0) begin
      errors++; $display("FAIL zero_pass: got pass=%b to=%b expected 1 0", pass, timeout_flag);
    end
  endtask

  task automatic test_abort_restart();
    int clr_seen, txen_cyc, t_done;
    bit d0;
    n_frames = 16'd2; err_limit = 32'd0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_frames = 16'd7; start = 1'b1; tick(); start = 1'b0; n_frames = 16'd2;
    checks++;
    if (clr_cnt !== 1'b0 || busy !== 1'b1 || tx_enable !== 1'b1) begin
      errors++; $display("FAIL ab_start_ignored: got clr=%b busy=%b txen=%b expected 0 1 1",
                         clr_cnt, busy, tx_enable);
    end
    ena_data_tx = 1'b1; tick(); ena_data_tx = 1'b0;
    ena_data_tx = 1'b1; tick(); ena_data_tx = 1'b0;
    checks++;
    if (tx_enable !== 1'b0 || busy !== 1'b1 || frames_tx !== 16'd2) begin
      errors++; $display("FAIL ab_drain: got txen=%b busy=%b tx=%0d expected 0 1 2",
                         tx_enable, busy, frames_tx);
    end
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || frames_tx !== 16'd2) begin
      errors++; $display("FAIL ab_idle: got done=%b busy=%b tx=%0d expected 0 0 2",
                         done, busy, frames_tx);
    end
    run_link(1, 0, 8'd0, 1'b1, 100, clr_seen, txen_cyc, t_done, d0);
    checks++;
    if (clr_seen !== 1 || t_done !== 17 || pass !== 1'b1 || frames_rx !== 16'd1) begin
      errors++; $display("FAIL ab_rerun: got clr=%0d t=%0d pass=%b rx=%0d expected 1 17 1 1",
                         clr_seen, t_done, pass, frames_rx);
    end
  endtask

  task automatic test_back_to_back();
    n_frames = 16'd1; err_limit = 32'd2; frame_err = 8'd2;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    ena_data_tx = 1'b1; ena_data_rx = 1'b1;
    tick();
    ena_data_tx = 1'b0; ena_data_rx = 1'b0;
    checks++;
    if (frames_tx !== 16'd1 || frames_rx !== 16'd1 || err_total !== 32'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_count: got tx=%0d rx=%0d err=%0d busy=%b expected 1 1 2 1",
                         frames_tx, frames_rx, err_total, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      errors++; $display("FAIL b2b_done: got done=%b pass=%b expected 1 1", done, pass);
    end
  endtask

  task automatic test_saturation();
    int clr_seen, txen_cyc, t_done;
    bit d0;
    run_link(3, 255, 8'hFF, 1'b1, 200, clr_seen, txen_cyc, t_done, d0);
    checks++;
    if (t_done !== 49 || done8 !== 1'b1 || frames_rx8 !== 16'd3) begin
      errors++; $display("FAIL sat_run: got t=%0d done8=%b rx8=%0d expected 49 1 3",
                         t_done, done8, frames_rx8);
    end
    checks++;
    if (err_total8 !== 8'hFF || pass8 !== 1'b1) begin
      errors++; $display("FAIL sat_err8: got err=%0h pass=%b expected ff 1", err_total8, pass8);
    end
    checks++;
    if (err_total !== 32'd765 || pass !== 1'b0) begin
      errors++; $display("FAIL sat_err32: got err=%0d pass=%b expected 765 0", err_total, pass);
    end
  endtask

  task automatic test_async_reset();
    n_frames = 16'd3; err_limit = 32'd0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    #2 reset_b = 1'b1;
    #1;
    checks++;
    if (tx_enable !== 1'b0 || busy !== 1'b0 || frames_tx !== 16'd0) begin
      errors++; $display("FAIL areset: got txen=%b busy=%b tx=%0d expected 0 0 0",
                         tx_enable, busy, frames_tx);
    end
    tick();
    reset_b = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_err_limit();
    test_timeout();
    test_zero_frames();
    test_abort_restart();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
